bcd_to_bin11: RTL

BCD_TO_BIN11 -- requirements
Module: bcd_to_bin11

---
 rtl/bcd_to_bin11.sv | 85 ++++++++
 1 files changed

// File: rtl/bcd_to_bin11.sv
// bcd_to_bin11: sequential 4-digit BCD to 11-bit binary converter using reverse double dabble.
module bcd_to_bin11 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic [10:0] bin,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t      r_state;
  logic [15:0] r_bcd;
  logic [10:0] r_res;
  logic [3:0]  r_cnt;
  logic [10:0] r_bin;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [15:0] w_sh;
  logic [15:0] w_nxt;
  logic [10:0] w_res;
  logic        w_bad;
  assign w_sh  = {1'b0, r_bcd[15:1]};
  assign w_res = {r_bcd[0], r_res[10:1]};
  // a digit >= 8 always has its MSB set, so the correction can never underflow
  for (genvar d = 0; d < 4; d++) begin : g_fix
    assign w_nxt[4*d +: 4] = w_sh[4*d+3] ? w_sh[4*d +: 4] - 4'd3 : w_sh[4*d +: 4];
  end
  assign w_bad = hundreds > 4'd9 || tens > 4'd9 || ones > 4'd9 || thousands > 4'd2 ||
                 (thousands == 4'd2 && (hundreds != 4'd0 || tens > 4'd4 || (tens == 4'd4 && ones > 4'd7)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_bcd  <= {thousands, hundreds, tens, ones};
          r_busy <= 1'b1;
          if (w_bad) begin
            r_state <= DONE;
            r_bin   <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state <= CONV;
            r_res   <= '0;
            r_cnt   <= '0;
          end
        end
        CONV: begin
          r_bcd <= w_nxt;
          r_res <= w_res;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) begin
            r_state <= DONE;
            r_bin   <= w_res;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bin  = r_bin;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
endmodule
